// File: rtl/sdrstick_pkg.sv
// Shared definitions for the sdrstick transmit feeder: register map,
// FSM state encoding and default widths.
package sdrstick_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int CNT_W_DEF    = 16;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_UFCOUNT = 3'd2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ_I = 3'd1;
    localparam state_t ST_CAP_I = 3'd2;
    localparam state_t ST_REQ_Q = 3'd3;
    localparam state_t ST_CAP_Q = 3'd4;
    localparam state_t ST_HOLD  = 3'd5;

endpackage

// File: rtl/sdrstick_tx_regs.sv
// CPU register file for the tx feeder: enable, sticky underflow flag and,
// when SDRSTICK_TX_UFCOUNT_EN is defined, a saturating underflow counter.
module sdrstick_tx_regs
    import sdrstick_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ctl_address,
    input  logic        ctl_read,
    input  logic        ctl_write,
    input  logic [31:0] ctl_writedata,
    output logic [31:0] ctl_readdata,
    input  logic        pair_valid,
    input  logic        underflow_evt,
    output logic        enable
);

    logic        underflow;
    logic        wr_ctrl;
    logic        wr_status;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign wr_ctrl      = ctl_write && (ctl_address == ADDR_CTRL);
    assign wr_status    = ctl_write && (ctl_address == ADDR_STATUS);
    assign unused_wdata = ^ctl_writedata;

`ifdef SDRSTICK_TX_UFCOUNT_EN
    logic [CNT_W-1:0] ufcount;
    logic             wr_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign wr_count = ctl_write && (ctl_address == ADDR_UFCOUNT);

    // An underflow in the same cycle as a clearing write still counts once.
    always_ff @(posedge clk) begin
        if (reset)
            ufcount <= '0;
        else if (underflow_evt)
            ufcount <= wr_count ? CNT_W'(1) : sat_inc(ufcount);
        else if (wr_count)
            ufcount <= '0;
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ctrl)
                enable <= ctl_writedata[0];
            if (underflow_evt)
                underflow <= 1'b1;
            else if (wr_status && ctl_writedata[1])
                underflow <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (ctl_address)
            ADDR_CTRL:    rd_mux[0]   = enable;
            ADDR_STATUS:  rd_mux[1:0] = {underflow, pair_valid};
`ifdef SDRSTICK_TX_UFCOUNT_EN
            ADDR_UFCOUNT: rd_mux[CNT_W-1:0] = ufcount;
`endif
            default:      rd_mux = '0;
        endcase
    end

    // A read colliding with a write leaves readdata untouched.
    always_ff @(posedge clk) begin
        if (reset)
            ctl_readdata <= '0;
        else if (ctl_read && !ctl_write)
            ctl_readdata <= rd_mux;
    end

endmodule

// File: rtl/sdrstick_tx_feeder.sv
// Pulls interleaved I/Q words from the CPU FIFO and presents one I/Q pair
// per interpolator strobe. Optional counter: SDRSTICK_TX_UFCOUNT_EN.
module sdrstick_tx_feeder
    import sdrstick_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         fifo_readdata,
    input  logic                fifo_empty,
    output logic                fifo_read,
    input  logic [2:0]          ctl_address,
    output logic [31:0]         ctl_readdata,
    input  logic                ctl_read,
    input  logic [31:0]         ctl_writedata,
    input  logic                ctl_write,
    input  logic                tx_strobe,
    output logic [SAMPLE_W-1:0] tx_i,
    output logic [SAMPLE_W-1:0] tx_q,
    output logic                tx_valid
);

    state_t              state;
    logic                enable;
    logic                pair_valid;
    logic                underflow_evt;
    logic [SAMPLE_W-1:0] pend_i;
    logic [SAMPLE_W-1:0] pend_q;
    logic                unused_word;

    assign unused_word   = ^fifo_readdata;
    assign fifo_read     = !reset && enable && !fifo_empty &&
                           (state == ST_REQ_I || state == ST_REQ_Q);
    assign underflow_evt = tx_strobe && enable && !pair_valid;

    sdrstick_tx_regs #(.CNT_W(CNT_W)) regs (
        .clk           (clk),
        .reset         (reset),
        .ctl_address   (ctl_address),
        .ctl_read      (ctl_read),
        .ctl_write     (ctl_write),
        .ctl_writedata (ctl_writedata),
        .ctl_readdata  (ctl_readdata),
        .pair_valid    (pair_valid),
        .underflow_evt (underflow_evt),
        .enable        (enable)
    );

    // Dropping enable returns to IDLE so a restart always begins with I.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_REQ_I;
                ST_REQ_I: if (!fifo_empty) state <= ST_CAP_I;
                ST_CAP_I: state <= ST_REQ_Q;
                ST_REQ_Q: if (!fifo_empty) state <= ST_CAP_Q;
                ST_CAP_Q: state <= ST_HOLD;
                ST_HOLD:  if (!pair_valid) state <= ST_REQ_I;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CAP_I)
            pend_i <= fifo_readdata[SAMPLE_W-1:0];
        if (state == ST_CAP_Q)
            pend_q <= fifo_readdata[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || !enable)
            pair_valid <= 1'b0;
        else if (state == ST_CAP_Q)
            pair_valid <= 1'b1;
        else if (tx_strobe)
            pair_valid <= 1'b0;
    end

    // Output stage: every strobe yields a 1-cycle-late valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_i     <= '0;
            tx_q     <= '0;
        end else begin
            tx_valid <= tx_strobe;
            if (tx_strobe) begin
                if (enable && pair_valid) begin
                    tx_i <= pend_i;
                    tx_q <= pend_q;
                end else begin
                    tx_i <= '0;
                    tx_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdrstick_tx_feeder.sv
// Scoreboard bench for sdrstick_tx_feeder: directed cases plus randomized
// traffic against a queue-based model of the feeder's observable behaviour.
`timescale 1ns/1ps
module tb_sdrstick_tx_feeder;

    localparam int SAMPLE_W = 24;
    localparam int CNT_W    = 16;
    localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_UFCOUNT = 3'd2;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         fifo_readdata;
    logic                fifo_empty;
    logic                fifo_read;
    logic [2:0]          ctl_address;
    logic [31:0]         ctl_readdata;
    logic                ctl_read;
    logic [31:0]         ctl_writedata;
    logic                ctl_write;
    logic                tx_strobe;
    logic [SAMPLE_W-1:0] tx_i;
    logic [SAMPLE_W-1:0] tx_q;
    logic                tx_valid;

    sdrstick_tx_feeder #(.SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_readdata (fifo_readdata),
        .fifo_empty    (fifo_empty),
        .fifo_read     (fifo_read),
        .ctl_address   (ctl_address),
        .ctl_readdata  (ctl_readdata),
        .ctl_read      (ctl_read),
        .ctl_writedata (ctl_writedata),
        .ctl_write     (ctl_write),
        .tx_strobe     (tx_strobe),
        .tx_i          (tx_i),
        .tx_q          (tx_q),
        .tx_valid      (tx_valid)
    );

    always #5 clk = ~clk;

    // CPU-side FIFO: words are appended by the stimulus, popped by the DUT.
    logic [31:0] fifo_mem[$];
    int          wr_cnt = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (rd_ptr >= wr_cnt);
    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_readdata <= fifo_mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
    } pair_t;

    typedef struct {
        string       nm;
        logic [31:0] got;
        logic [31:0] want;
    } chk_t;

    pair_t       exp_tx[$];
    logic [31:0] exp_rd[$];
    chk_t        chk_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic        m_en = 1'b0;
    logic        m_uf = 1'b0;
    int          m_cnt = 0;
    logic [31:0] last_rd = '0;
    int          seen;

    // Monitor: all comparisons happen here, on the falling edge.
    logic  rd_d = 1'b0;
    pair_t mon_p;
    logic [31:0] mon_r;
    chk_t  mon_c;
    always @(posedge clk) rd_d <= ctl_read && !ctl_write && !reset;

    always @(negedge clk) begin
        if (tx_valid) begin
            n_vec++;
            if (exp_tx.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected got i=%h q=%h want none", tx_i, tx_q);
            end else begin
                mon_p = exp_tx.pop_front();
                if (tx_i !== mon_p.i || tx_q !== mon_p.q) begin
                    n_err++;
                    $display("FAIL tx_pair got i=%h q=%h want i=%h q=%h",
                             tx_i, tx_q, mon_p.i, mon_p.q);
                end
            end
        end
        if (rd_d) begin
            n_vec++;
            if (exp_rd.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected got %h want none", ctl_readdata);
            end else begin
                mon_r = exp_rd.pop_front();
                if (ctl_readdata !== mon_r) begin
                    n_err++;
                    $display("FAIL ctl_read got %h want %h", ctl_readdata, mon_r);
                end
            end
        end
        while (chk_q.size() > 0) begin
            mon_c = chk_q.pop_front();
            n_vec++;
            if (mon_c.got !== mon_c.want) begin
                n_err++;
                $display("FAIL %s got %h want %h", mon_c.nm, mon_c.got, mon_c.want);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        chk_t c;
        c.nm = nm; c.got = got; c.want = want;
        chk_q.push_back(c);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem.push_back(w);
        wr_cnt++;
        mq.push_back(w);
    endtask

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            A_CTRL:    v[0] = m_en;
            A_STATUS:  v[1:0] = {m_uf, m_en && (mq.size() >= 2)};
`ifdef SDRSTICK_TX_UFCOUNT_EN
            A_UFCOUNT: v = m_cnt;
`endif
            default:   v = '0;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        if (a == A_CTRL) begin
            // Disabling discards whatever the feeder already pulled (at most a pair).
            if (m_en && !d[0]) begin
                if (mq.size() > 0) void'(mq.pop_front());
                if (mq.size() > 0) void'(mq.pop_front());
            end
            m_en = d[0];
        end else if (a == A_STATUS) begin
            if (d[1]) m_uf = 1'b0;
        end else if (a == A_UFCOUNT) begin
            m_cnt = 0;
        end
    endtask

    task automatic model_strobe();
        pair_t p;
        p = '0;
        if (m_en) begin
            if (mq.size() >= 2) begin
                p.i = mq[0][SAMPLE_W-1:0];
                p.q = mq[1][SAMPLE_W-1:0];
                void'(mq.pop_front());
                void'(mq.pop_front());
            end else begin
                m_uf = 1'b1;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
        exp_tx.push_back(p);
    endtask

    task automatic ctl_wr(input logic [2:0] a, input logic [31:0] d);
        ctl_address = a; ctl_writedata = d; ctl_write = 1'b1;
        model_write(a, d);
        tick(1);
        ctl_write = 1'b0;
    endtask

    task automatic ctl_rd(input logic [2:0] a);
        ctl_address = a; ctl_read = 1'b1;
        last_rd = model_reg(a);
        exp_rd.push_back(last_rd);
        tick(1);
        ctl_read = 1'b0;
    endtask

    task automatic strobe();
        tx_strobe = 1'b1;
        model_strobe();
        tick(1);
        tx_strobe = 1'b0;
    endtask

    task automatic strobe_wr(input logic [2:0] a, input logic [31:0] d);
        ctl_address = a; ctl_writedata = d; ctl_write = 1'b1; tx_strobe = 1'b1;
        model_write(a, d);
        model_strobe();
        tick(1);
        ctl_write = 1'b0; tx_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ctl_address = '0; ctl_writedata = '0; ctl_read = 1'b0; ctl_write = 1'b0;
        tx_strobe = 1'b0;
        tick(3);
        reset = 1'b0;
        chk("reset_tx_i", 32'(tx_i), 32'h0);
        chk("reset_tx_q", 32'(tx_q), 32'h0);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_fifo_read", 32'(fifo_read), 32'h0);
        chk("reset_readdata", ctl_readdata, 32'h0);
        ctl_rd(A_CTRL);

        // Basic pair
        push_word(32'h0012_3456); push_word(32'h00AB_CDEF);
        ctl_wr(A_CTRL, 32'h1);
        tick(12); strobe(); tick(12);
        ctl_rd(A_STATUS);

        // Upper bits ignored
        push_word(32'hFF00_0001); push_word(32'hEE00_0002);
        tick(12); strobe(); tick(12);

        // Underflow on empty FIFO, then clears
        repeat (3) begin strobe(); tick(2); end
        ctl_rd(A_STATUS); ctl_rd(A_UFCOUNT);
        ctl_wr(A_STATUS, 32'h2); ctl_rd(A_STATUS);
        ctl_wr(A_UFCOUNT, 32'h0); ctl_rd(A_UFCOUNT);

        // Clearing write racing an underflow: the event wins
        strobe_wr(A_STATUS, 32'h2); tick(1);
        strobe_wr(A_UFCOUNT, 32'h0); tick(1);
        ctl_rd(A_STATUS); ctl_rd(A_UFCOUNT);

        // Write and read together: write happens, readdata holds
        ctl_address = A_STATUS; ctl_writedata = 32'h2; ctl_write = 1'b1; ctl_read = 1'b1;
        model_write(A_STATUS, 32'h2);
        tick(1);
        ctl_write = 1'b0; ctl_read = 1'b0;
        chk("rd_hold_on_write", ctl_readdata, last_rd);
        ctl_rd(A_STATUS);

        // Partial fetch then disable; re-enable realigns on I
        push_word(32'h0000_0099);
        tick(12); ctl_wr(A_CTRL, 32'h0);
        tick(4); strobe(); tick(4);
        push_word(32'h0000_0010); push_word(32'h0000_0020);
        tick(4); ctl_wr(A_CTRL, 32'h1);
        tick(12); strobe(); tick(12);
        ctl_rd(A_STATUS);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) push_word($urandom);
            tick(12);
            case ($urandom_range(0, 7))
                0: begin ctl_wr(A_CTRL, 32'h0); tick(3); strobe(); tick(3); ctl_wr(A_CTRL, 32'h1); end
                1: ctl_rd(A_STATUS);
                2: ctl_rd(A_UFCOUNT);
                3: ctl_rd(3'd5);
                default: strobe();
            endcase
            tick(12);
        end

        // Drain so the FIFO is empty
        while (mq.size() >= 2) begin strobe(); tick(12); end
        ctl_wr(A_CTRL, 32'h0); tick(3); ctl_wr(A_CTRL, 32'h1); tick(12);
        ctl_wr(A_UFCOUNT, 32'h0);

        // Counter saturation
        tx_strobe = 1'b1;
        for (int n = 0; n < 70000; n++) begin
            model_strobe();
            tick(1);
        end
        tx_strobe = 1'b0;
        tick(3);
        ctl_rd(A_UFCOUNT); ctl_rd(A_STATUS);

        // Reset in the middle of CAP_Q
        ctl_rd(A_CTRL);
        tick(2);
        push_word(32'h0000_0AAA); push_word(32'h0000_0BBB);
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(negedge clk);
            if (fifo_read) seen++;
        end
        chk("capq_reached", 32'(seen), 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        mq.delete(); m_en = 1'b0; m_uf = 1'b0; m_cnt = 0;
        tick(1);
        chk("rst_capq_tx_i", 32'(tx_i), 32'h0);
        chk("rst_capq_tx_q", 32'(tx_q), 32'h0);
        chk("rst_capq_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_capq_fifo_read", 32'(fifo_read), 32'h0);
        chk("rst_capq_readdata", ctl_readdata, 32'h0);
        tick(1);
        reset = 1'b0;
        tick(2);
        ctl_rd(A_CTRL);
        strobe(); tick(2); strobe(); tick(3);
        ctl_rd(A_STATUS); ctl_rd(A_UFCOUNT);

        tick(5);
        chk("tx_leftover", 32'(exp_tx.size()), 32'h0);
        chk("rd_leftover", 32'(exp_rd.size()), 32'h0);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
